// File: rtl/color_mix_pal.sv
// ----------------------------------------------------------------------------
// color_mix_pal
//
// Palette-based video colour mixer. Each input pixel (IN_BITS per channel)
// indexes a host-writable palette RAM; the resulting colour (or a linear
// expansion of the input, depending on mix) is then passed through a
// colour / monochrome mix stage. Fixed latency of two ce_pix pulses, with the
// sync and blank signals delayed by the same amount.
//
// After reset the palette fills itself with a linear ramp, one entry per
// clk_vid cycle. Host writes are accepted once pal_ready is high.
//
// Ports:
//   clk_vid                  video clock
//   reset_n                  synchronous active-low reset
//   ce_pix                   pixel clock enable, advances both pipeline stages
//   mix[2:0]                 0 palette, 1 linear bypass, 2 green, 3 amber,
//                            4 cyan, 5 gray, 6/7 black
//   R_in/G_in/B_in           input pixel, IN_BITS per channel
//   HSync/VSync/HBlank/VBlank_in  timing inputs
//   pal_wr/pal_addr/pal_data palette write port, address and data are {R,G,B}
//   pal_ready                high when palette writes are accepted
//   R_out/G_out/B_out        output pixel, OUT_BITS per channel
//   HSync/VSync/HBlank/VBlank_out timing outputs, aligned to the pixel
// ----------------------------------------------------------------------------
module color_mix_pal #(
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 8
) (
    input  logic                    clk_vid,
    input  logic                    reset_n,
    input  logic                    ce_pix,
    input  logic [2:0]              mix,
    input  logic [IN_BITS-1:0]      R_in,
    input  logic [IN_BITS-1:0]      G_in,
    input  logic [IN_BITS-1:0]      B_in,
    input  logic                    HSync_in,
    input  logic                    VSync_in,
    input  logic                    HBlank_in,
    input  logic                    VBlank_in,
    input  logic                    pal_wr,
    input  logic [3*IN_BITS-1:0]    pal_addr,
    input  logic [3*OUT_BITS-1:0]   pal_data,
    output logic                    pal_ready,
    output logic [OUT_BITS-1:0]     R_out,
    output logic [OUT_BITS-1:0]     G_out,
    output logic [OUT_BITS-1:0]     B_out,
    output logic                    HSync_out,
    output logic                    VSync_out,
    output logic                    HBlank_out,
    output logic                    VBlank_out
);

    localparam int CH_N = 1 << IN_BITS;     // levels per input channel
    localparam int AW   = 3 * IN_BITS;      // palette address width
    localparam int N    = 1 << AW;          // palette depth
    localparam int DW   = 3 * OUT_BITS;     // palette word width
    localparam int PW   = OUT_BITS + 8;     // luma accumulator width

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Linear expansion of one channel value, evaluated only with constant
    // arguments so it folds into a lookup table at elaboration.
    function automatic logic [OUT_BITS-1:0] expand_val(input int v);
        longint num;
        num = longint'((1 << OUT_BITS) - 1) * longint'(v);
        return OUT_BITS'(num / longint'(CH_N - 1));
    endfunction

    logic [OUT_BITS-1:0] exp_lut [CH_N];

    for (genvar gi = 0; gi < CH_N; gi++) begin : g_lut
        assign exp_lut[gi] = expand_val(gi);
    end

    // ------------------------------------------------------------------
    // Init / run sequencer
    // ------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == AW'(N - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    assign pal_ready = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Palette RAM: one write port shared by init and host, one registered
    // read port driven by the pixel stream.
    // ------------------------------------------------------------------
    logic [DW-1:0] pal_mem [N];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] pal_rd_q;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = init_addr_q;
        wr_data = {exp_lut[init_addr_q[3*IN_BITS-1:2*IN_BITS]],
                   exp_lut[init_addr_q[2*IN_BITS-1:IN_BITS]],
                   exp_lut[init_addr_q[IN_BITS-1:0]]};
        if (reset_n) begin
            if (state_q == ST_INIT) begin
                wr_en = 1'b1;
            end else if (pal_wr) begin
                wr_en   = 1'b1;
                wr_addr = pal_addr;
                wr_data = pal_data;
            end
        end
    end

    assign rd_addr = {R_in, G_in, B_in};

    always_ff @(posedge clk_vid) begin
        if (wr_en) begin
            pal_mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-edge read of the address being written
    // returns the previous contents.
    always_ff @(posedge clk_vid) begin
        if (!reset_n) begin
            pal_rd_q <= '0;
        end else if (ce_pix) begin
            pal_rd_q <= pal_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 side registers and stage 2 mix
    // ------------------------------------------------------------------
    logic [DW-1:0] lin_q,   lin_d;
    logic [2:0]    mix1_q,  mix1_d;
    logic [3:0]    sync1_q, sync1_d;
    logic          run1_q,  run1_d;   // pixel was sampled after init finished
    logic [DW-1:0] rgb_q,   rgb_d;
    logic [3:0]    sync2_q, sync2_d;

    logic [DW-1:0]       src;
    logic [OUT_BITS-1:0] s_r, s_g, s_b;
    logic [PW-1:0]       px;
    logic [OUT_BITS-1:0] luma;
    logic [DW-1:0]       mixed;

    always_comb begin
        src  = (mix1_q == 3'd0) ? pal_rd_q : lin_q;
        s_r  = src[3*OUT_BITS-1:2*OUT_BITS];
        s_g  = src[2*OUT_BITS-1:OUT_BITS];
        s_b  = src[OUT_BITS-1:0];
        // Coefficients sum to 255, so the weighted sum always fits PW bits.
        px   = PW'(s_r) * PW'(54) + PW'(s_g) * PW'(183) + PW'(s_b) * PW'(18);
        luma = px[PW-1:8];

        case (mix1_q)
            3'd0, 3'd1: mixed = src;
            3'd2:       mixed = {{OUT_BITS{1'b0}}, luma, {OUT_BITS{1'b0}}};
            3'd3:       mixed = {luma, luma - (luma >> 2), {OUT_BITS{1'b0}}};
            3'd4:       mixed = {{OUT_BITS{1'b0}}, luma, luma};
            3'd5:       mixed = {luma, luma, luma};
            default:    mixed = '0;
        endcase

        // Pixels read while the palette was still filling may carry
        // undefined RAM contents, so they are blanked as well.
        if (!run1_q || state_q != ST_RUN) begin
            mixed = '0;
        end
    end

    always_comb begin
        lin_d   = lin_q;
        mix1_d  = mix1_q;
        sync1_d = sync1_q;
        run1_d  = run1_q;
        rgb_d   = rgb_q;
        sync2_d = sync2_q;
        if (ce_pix) begin
            lin_d   = {exp_lut[R_in], exp_lut[G_in], exp_lut[B_in]};
            mix1_d  = mix;
            sync1_d = {HSync_in, VSync_in, HBlank_in, VBlank_in};
            run1_d  = pal_ready;
            rgb_d   = mixed;
            sync2_d = sync1_q;
        end
    end

    always_ff @(posedge clk_vid) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            lin_q       <= '0;
            mix1_q      <= '0;
            sync1_q     <= '0;
            run1_q      <= 1'b0;
            rgb_q       <= '0;
            sync2_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            lin_q       <= lin_d;
            mix1_q      <= mix1_d;
            sync1_q     <= sync1_d;
            run1_q      <= run1_d;
            rgb_q       <= rgb_d;
            sync2_q     <= sync2_d;
        end
    end

    assign R_out      = rgb_q[3*OUT_BITS-1:2*OUT_BITS];
    assign G_out      = rgb_q[2*OUT_BITS-1:OUT_BITS];
    assign B_out      = rgb_q[OUT_BITS-1:0];
    assign HSync_out  = sync2_q[3];
    assign VSync_out  = sync2_q[2];
    assign HBlank_out = sync2_q[1];
    assign VBlank_out = sync2_q[0];

endmodule
